// File: rtl/instruction_memory.sv
// Word-addressed instruction store for the MiniMicro fetch stage.
// Combinational read port indexed by the program counter; synchronous program-load port.
// Reset fills every word with NOP_WORD so fetch never sees X.
// Build option: define INSTR_MEM_LOAD_EN to enable the load port. When it is undefined,
// the block is a reset-initialised ROM of NOPs and the load inputs are ignored.
module instruction_memory #(
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned MEM_LENGTH  = 32,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013,
  localparam int unsigned AW         = $clog2(MEM_LENGTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AW-1:0]          address,
  output logic [DATA_LENGTH-1:0] return_data,
  output logic                   addr_error,
  input  logic                   load_en,
  input  logic [AW-1:0]          load_address,
  input  logic [DATA_LENGTH-1:0] load_data,
  output logic                   load_error
);

  localparam int unsigned AwP1 = AW + 1;

  // NOP image adapted to the configured word width (truncate or zero-extend).
  localparam logic [DATA_LENGTH-1:0] NopFill = DATA_LENGTH'(NOP_WORD);

  // Depth widened by one bit so the range check also works when MEM_LENGTH is a power of two.
  localparam logic [AW:0] MemLen = AwP1'(MEM_LENGTH);

  logic [DATA_LENGTH-1:0] mem_q [MEM_LENGTH];
  logic                   addr_oor;

  // Fetch path: range check and word select, no clock involved.
  always_comb begin
    addr_oor    = ({1'b0, address} >= MemLen);
    addr_error  = addr_oor;
    return_data = addr_oor ? NopFill : mem_q[address];
  end

`ifdef INSTR_MEM_LOAD_EN

  logic load_oor;
  logic wr_en;
  logic load_error_d;
  logic load_error_q;

  // Decode the load strobe into an in-range write or an out-of-range error flag.
  always_comb begin
    load_oor     = ({1'b0, load_address} >= MemLen);
    wr_en        = load_en & ~load_oor;
    load_error_d = load_en & load_oor;
  end

  // Storage and error flag; reset wins over a concurrent load.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MEM_LENGTH; i++) begin
        mem_q[AW'(i)] <= NopFill;
      end
      load_error_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[load_address] <= load_data;
      end
      load_error_q <= load_error_d;
    end
  end

  assign load_error = load_error_q;

`else

  // ROM mode: contents only ever change to the NOP image on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MEM_LENGTH; i++) begin
        mem_q[AW'(i)] <= NopFill;
      end
    end
  end

  // Load port is present for pin compatibility but has no effect.
  logic unused_load;
  assign unused_load = ^{load_en, load_address, load_data};
  assign load_error  = 1'b0;

`endif

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: a 32-word and a 20-word instance share all inputs
// and are compared against array models updated at each rising clock edge.
module tb_instruction_memory;

`ifdef INSTR_MEM_LOAD_EN
  localparam bit LoadEn = 1'b1;
`else
  localparam bit LoadEn = 1'b0;
`endif

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [4:0]  address;
  logic        load_en;
  logic [4:0]  load_address;
  logic [31:0] load_data;

  logic [31:0] rd32, rd20;
  logic        ae32, ae20;
  logic        le32, le20;

  int vectors;
  int miscompares;

  // Reference model: plain word arrays plus the expected error flag of the short memory.
  logic [31:0] m32 [32];
  logic [31:0] m20 [20];
  logic        exp_le20;

  instruction_memory #(.MEM_LENGTH(32)) u_dut32 (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .return_data  (rd32),
    .addr_error   (ae32),
    .load_en      (load_en),
    .load_address (load_address),
    .load_data    (load_data),
    .load_error   (le32)
  );

  instruction_memory #(.MEM_LENGTH(20)) u_dut20 (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .return_data  (rd20),
    .addr_error   (ae20),
    .load_en      (load_en),
    .load_address (load_address),
    .load_data    (load_data),
    .load_error   (le20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge; the model applies the write rules to the inputs present at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m32[i] = Nop;
      for (int i = 0; i < 20; i++) m20[i] = Nop;
      exp_le20 = 1'b0;
    end else begin
      if (LoadEn && load_en) m32[load_address] = load_data;
      if (LoadEn && load_en && load_address < 5'd20) m20[load_address] = load_data;
      exp_le20 = LoadEn && load_en && (load_address >= 5'd20);
    end
    #1;
  endtask

  task automatic check_rd(input string tag);
    logic [31:0] e20;
    if (address < 5'd20) e20 = m20[address];
    else                 e20 = Nop;
    chk({tag, "/rd32"}, rd32, m32[address]);
    chk({tag, "/ae32"}, {31'b0, ae32}, 32'd0);
    chk({tag, "/rd20"}, rd20, e20);
    chk({tag, "/ae20"}, {31'b0, ae20}, {31'b0, address >= 5'd20});
  endtask

  task automatic check_le(input string tag);
    chk({tag, "/le32"}, {31'b0, le32}, 32'd0);
    chk({tag, "/le20"}, {31'b0, le20}, {31'b0, exp_le20});
  endtask

  task automatic sweep_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      address = 5'(i);
      #1;
      check_rd(tag);
    end
  endtask

  initial begin
    logic [4:0] sweep [8];
    vectors      = 0;
    miscompares  = 0;
    exp_le20     = 1'b0;
    rst          = 1'b1;
    address      = 5'd0;
    load_en      = 1'b0;
    load_address = 5'd0;
    load_data    = 32'd0;

    // Reset, then fetch sweep in 5 ns steps: every word is the NOP image.
    tick();
    rst = 1'b0;
    check_le("reset");
    sweep = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd30, 5'd31};
    for (int i = 0; i < 8; i++) begin
      address = sweep[i];
      #2;
      check_rd("reset_sweep");
      chk("reset_nop", rd32, 32'h0000_0013);
      #3;
    end

    // Program load of the full 32-word image.
    load_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      load_address = 5'(i);
      load_data    = 32'hA5A5_0000 + 32'(i);
      tick();
      check_le("load_full");
    end
    load_en = 1'b0;
    tick();
    check_le("load_idle");
    for (int i = 1; i < 8; i++) begin
      address = sweep[i];
      #1;
      check_rd("load_read");
    end
    address = 5'(32);
    #1;
    check_rd("wrap32");

    // Same-address write: old word before the edge, new word right after it.
    address      = 5'd7;
    load_en      = 1'b1;
    load_address = 5'd7;
    load_data    = 32'hDEAD_BEEF;
    #1;
    check_rd("hold_pre");
    tick();
    check_rd("hold_post");

    // Out-of-range write on the 20-word memory: one-cycle error, contents untouched.
    load_address = 5'd25;
    load_data    = 32'hCAFE_F00D;
    address      = 5'd25;
    #1;
    check_rd("oor_read");
    tick();
    check_le("oor_write");
    load_en = 1'b0;
    tick();
    check_le("oor_clear");
    sweep_all("oor_nochange");

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 300; n++) begin
      rst          = ($urandom_range(0, 15) == 0);
      load_en      = $urandom_range(0, 1) == 1;
      load_address = 5'($urandom);
      load_data    = $urandom;
      tick();
      check_le("rand_le");
      address = 5'($urandom);
      #1;
      check_rd("rand_rd");
    end
    rst     = 1'b0;
    load_en = 1'b0;

    // Reset during a load sequence: the concurrent write is dropped, everything reads NOP.
    load_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      load_address = 5'(i);
      load_data    = 32'h5A5A_0000 + 32'(i);
      tick();
    end
    rst          = 1'b1;
    load_address = 5'd3;
    load_data    = 32'h1234_5678;
    tick();
    rst     = 1'b0;
    load_en = 1'b0;
    check_le("rst_load");
    sweep_all("rst_load");
    address = 5'd3;
    #1;
    chk("rst_word3", rd32, 32'h0000_0013);

    // Write all-ones to word 0: lands only when the load port is built in.
    load_en      = 1'b1;
    load_address = 5'd0;
    load_data    = 32'hFFFF_FFFF;
    tick();
    load_en = 1'b0;
    check_le("w0_ones");
    address = 5'd0;
    #1;
    check_rd("w0_ones");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_memory.md
# instruction_memory

Word-addressed instruction store for the MiniMicro microprocessor. It feeds the fetch stage through a combinational read port indexed by the program counter. A synchronous load port writes program words. Reset restores every word to a known NOP image so fetch never returns X.

## Interface
- DATA_LENGTH, default 32: instruction word width in bits.
- MEM_LENGTH, default 32: number of words; any value ≥ 2, power of two not required.
- NOP_WORD, default 32'h0000_0013: reset/fill value, truncated or zero-extended to DATA_LENGTH.
- AW (localparam) = $clog2(MEM_LENGTH): address width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- address  in  AW  fetch address, in words.
- return_data  out  DATA_LENGTH  instruction at `address`, combinational.
- addr_error  out  1  high when `address` ≥ MEM_LENGTH, combinational.
- load_en  in  1  write strobe for the program-load port.
- load_address  in  AW  word address for the write.
- load_data  in  DATA_LENGTH  word to write.
- load_error  out  1  registered; high for one cycle after a write attempt to an out-of-range address.

## Operation
- Storage is an array of MEM_LENGTH words of DATA_LENGTH bits.
- Read path:
  - return_data = mem[address] when address < MEM_LENGTH.
  - Otherwise return_data = NOP_WORD and addr_error = 1.
  - The read path is purely combinational; no clock is involved.
- Address arithmetic is AW bits with no carry. A value of MEM_LENGTH applied to a power-of-two memory truncates and wraps to word 0. Example: 32 on a 5-bit address reads word 0 with addr_error = 0.
- Write path, evaluated at each rising clk:
  - rst = 1: every word is set to NOP_WORD and load_error is cleared. Any load_en in that cycle is ignored; reset has priority.
  - load_en = 1 and load_address < MEM_LENGTH: mem[load_address] ← load_data; load_error ← 0.
  - load_en = 1 and load_address ≥ MEM_LENGTH: memory is unchanged; load_error ← 1.
  - load_en = 0: memory is unchanged; load_error ← 0.
- Only one write port exists, so there are no write–write collisions.

## Timing
- Read latency is zero clock cycles. return_data settles within combinational delay of any change to `address` or to the addressed word.
- Write becomes visible at the rising edge. When address equals load_address, return_data shows the old word before the edge and the new word immediately after it; there is no write-through bypass.
- Reset takes one rising edge with rst high. From that edge until the next write, every in-range address reads NOP_WORD, addr_error follows `address` only, and load_error = 0.
- Before the first reset, memory contents are undefined. The fetch stage must not issue reads before reset.
- If reset is asserted while a load sequence is in progress, all words written so far are discarded. The loader must restart after rst deasserts.

## Configuration
- INSTR_MEM_LOAD_EN defined: the load port is functional as described above.
- INSTR_MEM_LOAD_EN undefined:
  - load_en, load_address and load_data are present but ignored.
  - load_error is tied to 0.
  - Memory holds NOP_WORD after reset and cannot be modified. It acts as a reset-initialised ROM of NOPs, used for fetch-path bring-up.

## Test plan
- Reset, then sweep address 0, 1, 2, 3, 4, 5, 30, 31 with 5 ns steps → return_data = 0x00000013 at every address; addr_error = 0.
- With INSTR_MEM_LOAD_EN: write word i = 0xA5A50000 + i for i = 0..31, then read addresses 1, 2, 3, 4, 5, 30, 31 → returns 0xA5A50001 … 0xA5A5001F respectively. Drive address = 32 (truncates to 0) → returns 0xA5A50000.
- Hold address = 7, write 0xDEADBEEF to address 7 → return_data stays at the old value until the clk edge and is 0xDEADBEEF right after it.
- With MEM_LENGTH = 20: read address 25 → return_data = 0x00000013 and addr_error = 1. Write to address 25 → load_error = 1 for exactly one cycle and no word changes.
- Load the full memory, then assert rst together with load_en (address 3, data 0x12345678) for one edge → every word reads 0x00000013; word 3 is not 0x12345678.
- Without INSTR_MEM_LOAD_EN: write 0xFFFFFFFF to address 0 → address 0 still reads 0x00000013; load_error = 0.
